pc_unit: RTL and testbench
==========================

# pc_unit

Program counter and branch unit for the one-cycle CPU. It sits directly downstream of the flag register and consumes its carry, zero and borrow outputs to resolve conditional jumps. It also holds a small hardware return stack for CALL/RET. Its registered PC output drives the instruction memory address each cycle.

## Interface
- ADDR_W, 8, PC and jump-target width in bits.
- STACK_DEPTH, 4, return-stack entries; power of two, at least 2.
- RESET_VEC, 0, PC value loaded on reset.

- clk  in  1  system clock; all state changes on the rising edge.
- pc_rst_n  in  1  reset, asynchronous and active-low; clears all state immediately.
- pc_en  in  1  advance enable; 0 freezes PC, stack and pc_taken.
- pc_op  in  3  operation code:
  - 000 NEXT
  - 001 JMP
  - 010 JC
  - 011 JZ
  - 100 JB
  - 101 CALL
  - 110 RET
  - 111 JNZ
- pc_target  in  ADDR_W  absolute jump/call target.
- flag_c  in  1  carry flag from the flag register.
- flag_z  in  1  zero flag from the flag register.
- flag_b  in  1  borrow flag from the flag register.
- err_clr  in  1  synchronous clear of the sticky error flags.
- pc  out  ADDR_W  current program counter; registered.
- pc_taken  out  1  registered; 1 when the previous enabled cycle redirected the PC.
- stk_ovf  out  1  sticky; set when a CALL found the stack full.
- stk_unf  out  1  sticky; set when a RET found the stack empty.

## Operation
- pc_inc = pc + 1, modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0 with no error.
- Next-PC selection when pc_en=1:
  - NEXT: pc_inc.
  - JMP: pc_target.
  - JC, JZ, JB: pc_target if flag_c, flag_z or flag_b respectively is 1; else pc_inc.
  - JNZ: pc_target if flag_z=0; else pc_inc.
  - CALL, stack not full: push pc_inc, load pc_target.
  - CALL, stack full: no push, PC gets pc_inc, stk_ovf set.
  - RET, stack not empty: pop top into PC.
  - RET, stack empty: PC gets pc_inc, stk_unf set.
- pc_taken is 1 after an edge where the PC was loaded from pc_target or from the stack; 0 otherwise, including failed CALL/RET.
- Stack pointer sp is a count of valid entries, width $clog2(STACK_DEPTH)+1.
  - full is sp==STACK_DEPTH; empty is sp==0.
  - Push writes entry[sp], then sp+1; pop reads entry[sp-1], then sp-1.
- Flags are sampled combinationally in the same cycle as pc_op. They are the flag register's current outputs, not values being written that cycle.
- err_clr is honoured regardless of pc_en. If err_clr and a new error occur in the same cycle, the error wins and the flag stays 1.
- pc_en=0: PC, sp, stack contents and pc_taken hold. stk_ovf and stk_unf change only through err_clr.

## Timing
- Reset (pc_rst_n=0, asynchronous): pc=RESET_VEC, sp=0, pc_taken=0, stk_ovf=0, stk_unf=0. Stack entry contents are don't-care.
- Reset deassertion is sampled at the next rising edge. The first enabled edge after release moves the PC from RESET_VEC.
- Reset mid-CALL/RET: the operation is discarded and the stack reads empty afterwards.
- Latency: one cycle. pc_op, pc_target and flags presented in cycle N produce the new pc and pc_taken after edge N.
- Back-to-back CALL/RET on consecutive cycles are fully supported; no bubbles are required.
- No combinational path from any input to pc or pc_taken.

## Structure
- Package pc_pkg holds:
  - the pc_op localparams: OP_NEXT, OP_JMP, OP_JC, OP_JZ, OP_JB, OP_CALL, OP_RET, OP_JNZ;
  - a shared flag-index constant.
- Sub-module ret_stack: parameterised LIFO (ADDR_W, STACK_DEPTH).
  - Inputs: push, pop, din.
  - Outputs: dout (top entry), full, empty.
  - Async active-low reset clears sp only.
- pc_unit contains the next-PC mux, condition decode, PC register and sticky error flags.

## Test plan
- Reset sequencing: pc_rst_n low for 2 cycles, then NEXT with pc_en=1 for 3 edges. Expected pc 0→1→2→3, pc_taken=0 throughout.
- Conditional jumps: at pc=5, JC target 0x40 with flag_c=0 gives pc=6, pc_taken=0. Then JC target 0x40 with flag_c=1 gives pc=0x40, pc_taken=1. Then JNZ target 0x10 with flag_z=1 gives pc=0x41.
- Call nesting:
  - From pc=0x10, four CALLs with targets 0x20, 0x30, 0x40, 0x50 push 0x11, 0x21, 0x31, 0x41.
  - A fifth CALL at pc=0x50 gives pc=0x51 and stk_ovf=1.
  - Four RETs then give 0x41, 0x31, 0x21, 0x11.
- Underflow and clear: RET on an empty stack at pc=0x11 gives pc=0x12 and stk_unf=1. Holding err_clr=1 for one edge gives stk_unf=0. err_clr together with a failing RET leaves stk_unf=1.
- Wrap and hold:
  - With pc=0xFF, NEXT gives pc=0x00 and no error flag.
  - With pc_en=0 for 3 cycles and JMP 0x80 applied, pc stays 0x00.
- Async reset mid-operation: assert pc_rst_n=0 between edges during a CALL with 2 entries on the stack. pc becomes RESET_VEC immediately. A following RET sets stk_unf=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared opcode encodings and flag-vector layout for the program counter / branch unit.
package pc_pkg;

   localparam logic [2:0] OP_NEXT = 3'b000;
   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_JC   = 3'b010;
   localparam logic [2:0] OP_JZ   = 3'b011;
   localparam logic [2:0] OP_JB   = 3'b100;
   localparam logic [2:0] OP_CALL = 3'b101;
   localparam logic [2:0] OP_RET  = 3'b110;
   localparam logic [2:0] OP_JNZ  = 3'b111;

   // Bit positions of carry/zero/borrow inside the packed flag vector.
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_B = 2;
   localparam int FLAG_W = 3;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO; sp counts valid entries, dout always shows the top entry.
module ret_stack #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = IDX_W + 1;

   logic [SP_W-1:0]   sp;
   logic [ADDR_W-1:0] entry [STACK_DEPTH];
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   assign full   = (sp == SP_W'(STACK_DEPTH));
   assign empty  = (sp == '0);
   assign wr_idx = sp[IDX_W-1:0];
   // When empty this wraps to the last slot; the value is ignored by the consumer.
   assign rd_idx = IDX_W'(sp - SP_W'(1));
   assign dout   = entry[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + SP_W'(1);
      end else if (pop && !empty) begin
         sp <= sp - SP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         entry[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with conditional branch resolution, CALL/RET return stack and sticky stack errors.
module pc_unit
   import pc_pkg::*;
#(
   parameter int                ADDR_W      = 8,
   parameter int                STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
   input  logic              clk,
   input  logic              pc_rst_n,
   input  logic              pc_en,
   input  logic [2:0]        pc_op,
   input  logic [ADDR_W-1:0] pc_target,
   input  logic              flag_c,
   input  logic              flag_z,
   input  logic              flag_b,
   input  logic              err_clr,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_taken,
   output logic              stk_ovf,
   output logic              stk_unf
);

   logic [FLAG_W-1:0] flags;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] stk_top;
   logic              taken_next;
   logic              stk_full;
   logic              stk_empty;
   logic              do_push;
   logic              do_pop;
   logic              ovf_set;
   logic              unf_set;

   always_comb begin
      flags         = '0;
      flags[FLAG_C] = flag_c;
      flags[FLAG_Z] = flag_z;
      flags[FLAG_B] = flag_b;
   end

   assign pc_inc = pc + ADDR_W'(1);

   always_comb begin
      pc_next    = pc_inc;
      taken_next = 1'b0;
      do_push    = 1'b0;
      do_pop     = 1'b0;
      ovf_set    = 1'b0;
      unf_set    = 1'b0;
      case (pc_op)
         OP_NEXT: ;
         OP_JMP:  taken_next = 1'b1;
         OP_JC:   taken_next = flags[FLAG_C];
         OP_JZ:   taken_next = flags[FLAG_Z];
         OP_JB:   taken_next = flags[FLAG_B];
         OP_JNZ:  taken_next = !flags[FLAG_Z];
         OP_CALL: begin
            if (stk_full) begin
               ovf_set = 1'b1;
            end else begin
               do_push    = 1'b1;
               taken_next = 1'b1;
            end
         end
         OP_RET: begin
            if (stk_empty) begin
               unf_set = 1'b1;
            end else begin
               do_pop     = 1'b1;
               taken_next = 1'b1;
               pc_next    = stk_top;
            end
         end
         default: ;
      endcase
      if (taken_next && pc_op != OP_RET) begin
         pc_next = pc_target;
      end
   end

   ret_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .rst_n (pc_rst_n),
      .push  (pc_en && do_push),
      .pop   (pc_en && do_pop),
      .din   (pc_inc),
      .dout  (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

   always_ff @(posedge clk or negedge pc_rst_n) begin
      if (!pc_rst_n) begin
         pc       <= RESET_VEC;
         pc_taken <= 1'b0;
      end else if (pc_en) begin
         pc       <= pc_next;
         pc_taken <= taken_next;
      end
   end

   // A new error outranks a simultaneous clear.
   always_ff @(posedge clk or negedge pc_rst_n) begin
      if (!pc_rst_n) begin
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
      end else begin
         stk_ovf <= (pc_en && ovf_set) || (stk_ovf && !err_clr);
         stk_unf <= (pc_en && unf_set) || (stk_unf && !err_clr);
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed plus randomized check of pc_unit against a queue-based behavioural model.
module tb_pc_unit;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk;
   logic              pc_rst_n;
   logic              pc_en;
   logic [2:0]        pc_op;
   logic [ADDR_W-1:0] pc_target;
   logic              flag_c;
   logic              flag_z;
   logic              flag_b;
   logic              err_clr;
   logic [ADDR_W-1:0] pc;
   logic              pc_taken;
   logic              stk_ovf;
   logic              stk_unf;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int m_pc;
   int m_taken;
   int m_ovf;
   int m_unf;
   int m_stack[$];

   pc_unit #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (DEPTH),
      .RESET_VEC   (8'h00)
   ) dut (
      .clk       (clk),
      .pc_rst_n  (pc_rst_n),
      .pc_en     (pc_en),
      .pc_op     (pc_op),
      .pc_target (pc_target),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .flag_b    (flag_b),
      .err_clr   (err_clr),
      .pc        (pc),
      .pc_taken  (pc_taken),
      .stk_ovf   (stk_ovf),
      .stk_unf   (stk_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = 0;
      m_taken = 0;
      m_ovf   = 0;
      m_unf   = 0;
      m_stack.delete();
   endtask

   task automatic model_edge(input int op, input int tgt, input bit en,
                             input bit c, input bit z, input bit b, input bit clr);
      int inc;
      int nxt;
      bit tk;
      bit ovf_hit;
      bit unf_hit;
      inc     = (m_pc + 1) % 256;
      nxt     = inc;
      tk      = 0;
      ovf_hit = 0;
      unf_hit = 0;
      case (op)
         1: tk = 1;
         2: tk = c;
         3: tk = z;
         4: tk = b;
         7: tk = !z;
         5: begin
            if (m_stack.size() == DEPTH) ovf_hit = 1;
            else begin
               tk = 1;
               if (en) m_stack.push_back(inc);
            end
         end
         6: begin
            if (m_stack.size() == 0) unf_hit = 1;
            else begin
               tk  = 1;
               nxt = m_stack[$];
               if (en) void'(m_stack.pop_back());
            end
         end
         default: ;
      endcase
      if (tk && op != 6) nxt = tgt;
      if (en) begin
         m_pc    = nxt;
         m_taken = tk;
      end
      m_ovf = (en && ovf_hit) ? 1 : (clr ? 0 : m_ovf);
      m_unf = (en && unf_hit) ? 1 : (clr ? 0 : m_unf);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},    32'(pc),       32'(m_pc));
      check({tag, ".taken"}, 32'(pc_taken), 32'(m_taken));
      check({tag, ".ovf"},   32'(stk_ovf),  32'(m_ovf));
      check({tag, ".unf"},   32'(stk_unf),  32'(m_unf));
   endtask

   // Drive one cycle of inputs, advance one rising edge, then compare.
   task automatic step(input string tag, input int op, input int tgt, input bit en,
                       input bit c, input bit z, input bit b, input bit clr);
      pc_op     = 3'(op);
      pc_target = 8'(tgt);
      pc_en     = en;
      flag_c    = c;
      flag_z    = z;
      flag_b    = b;
      err_clr   = clr;
      @(posedge clk);
      model_edge(op, tgt, en, c, z, b, clr);
      #1;
      $display("%s op=%0d tgt=0x%02h en=%0b cz b=%0b%0b%0b clr=%0b -> pc=0x%02h taken=%0b ovf=%0b unf=%0b",
               tag, op, tgt[7:0], en, c, z, b, clr, pc, pc_taken, stk_ovf, stk_unf);
      check_all(tag);
   endtask

   // Assert reset between edges, check the immediate effect, release before the next edge.
   task automatic async_reset(input string tag);
      #2;
      pc_rst_n = 1'b0;
      model_reset();
      #1;
      check_all({tag, ".async"});
      #1;
      pc_rst_n = 1'b1;
   endtask

   initial begin
      pc_rst_n  = 1'b1;
      pc_en     = 1'b0;
      pc_op     = 3'd0;
      pc_target = '0;
      flag_c    = 1'b0;
      flag_z    = 1'b0;
      flag_b    = 1'b0;
      err_clr   = 1'b0;
      model_reset();

      #2 pc_rst_n = 1'b0;
      #1 check_all("reset");
      pc_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_all("reset_hold");
      pc_rst_n = 1'b1;

      step("seq1", 0, 0, 1, 0, 0, 0, 0);
      step("seq2", 0, 0, 1, 0, 0, 0, 0);
      step("seq3", 0, 0, 1, 0, 0, 0, 0);
      check("seq3_pc_abs", 32'(pc), 32'h3);
      step("to4", 0, 0, 1, 0, 0, 0, 0);
      step("to5", 0, 0, 1, 0, 0, 0, 0);

      step("jc_nt", 2, 8'h40, 1, 0, 0, 0, 0);
      check("jc_nt_abs", 32'(pc), 32'h6);
      step("jc_t", 2, 8'h40, 1, 1, 0, 0, 0);
      check("jc_t_abs", 32'(pc), 32'h40);
      step("jnz_nt", 7, 8'h10, 1, 0, 1, 0, 0);
      check("jnz_nt_abs", 32'(pc), 32'h41);
      step("jz_t", 3, 8'h10, 1, 0, 1, 0, 0);

      step("call1", 5, 8'h20, 1, 0, 0, 0, 0);
      step("call2", 5, 8'h30, 1, 0, 0, 0, 0);
      step("call3", 5, 8'h40, 1, 0, 0, 0, 0);
      step("call4", 5, 8'h50, 1, 0, 0, 0, 0);
      step("call5_ovf", 5, 8'h60, 1, 0, 0, 0, 0);
      check("call5_abs", 32'(pc), 32'h51);
      step("ret1", 6, 0, 1, 0, 0, 0, 0);
      check("ret1_abs", 32'(pc), 32'h41);
      step("ret2", 6, 0, 1, 0, 0, 0, 0);
      step("ret3", 6, 0, 1, 0, 0, 0, 0);
      step("ret4", 6, 0, 1, 0, 0, 0, 0);
      check("ret4_abs", 32'(pc), 32'h11);

      step("ret_unf", 6, 0, 1, 0, 0, 0, 0);
      check("ret_unf_abs", 32'(stk_unf), 32'h1);
      step("clr", 0, 0, 0, 0, 0, 0, 1);
      step("clr_vs_unf", 6, 0, 1, 0, 0, 0, 1);
      check("clr_vs_unf_abs", 32'(stk_unf), 32'h1);
      step("clr2", 0, 0, 0, 0, 0, 0, 1);

      step("jmp_ff", 1, 8'hFF, 1, 0, 0, 0, 0);
      step("wrap", 0, 0, 1, 0, 0, 0, 0);
      check("wrap_abs", 32'(pc), 32'h0);
      for (int i = 0; i < 3; i++) step("hold", 1, 8'h80, 0, 0, 0, 0, 0);

      step("pre_call1", 5, 8'h20, 1, 0, 0, 0, 0);
      step("pre_call2", 5, 8'h30, 1, 0, 0, 0, 0);
      pc_op     = 3'd5;
      pc_target = 8'h40;
      async_reset("mid_call");
      step("ret_after_rst", 6, 0, 1, 0, 0, 0, 0);
      check("ret_after_rst_abs", 32'(stk_unf), 32'h1);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 2) async_reset("rnd");
         step("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
              ($urandom_range(0, 99) < 85), 1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 99) < 10));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
